fetch_pipeline_controller: RTL and testbench
============================================

Name: fetch_pipeline_controller

Overview:
Responder side of the hazard-control interface. Consumes the active-low hold request (`stall`) and `branch_taken` from the hazard detection logic. Converts them into the PC write enable, the next-PC select, the ID/EX bubble, and the IF/ID pipeline register contents. Sits between the fetch stage (PC register, instruction memory) and the decode stage.

Parameters:
- DATA_WIDTH, 32, width of PC and instruction.
- FLUSH_CYCLES, 1, number of IF/ID slots squashed after a taken branch (legal range 1..7).
- MAX_HOLD_CYCLES, 15, consecutive hold cycles after which hold_timeout is raised (legal range 1..255).
- NOP_INSTRUCTION, 32'h00000013, encoding loaded into IF/ID on a squash or bubble.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- stall  input  1  hold request, active-low: 0 = hold the front end, 1 = run
- branch_taken  input  1  redirect request, active-high
- branch_target  input  DATA_WIDTH  redirect PC, valid while branch_taken=1
- fetch_pc  input  DATA_WIDTH  PC of the instruction currently fetched
- fetch_instruction  input  DATA_WIDTH  instruction currently fetched
- pc_write_enable  output  1  PC register load enable
- next_pc_select  output  1  0 = PC+4, 1 = branch_target
- id_ex_bubble  output  1  force the ID/EX control fields to zero this cycle
- if_id_pc  output  DATA_WIDTH  registered PC into decode
- if_id_instruction  output  DATA_WIDTH  registered instruction into decode
- if_id_valid  output  1  registered valid into decode
- hold_timeout  output  1  sticky watchdog flag
- stall_cycle_count  output  16  hold cycles seen (optional feature)
- flush_count  output  16  redirects seen (optional feature)

Behaviour:
- Reset, asynchronous on reset_n=0:
  - state = RUN, flush counter = 0, hold counter = 0.
  - if_id_pc = 0, if_id_instruction = NOP_INSTRUCTION, if_id_valid = 0.
  - hold_timeout = 0, both stat counters = 0.
  - Combinational outputs during reset: pc_write_enable=1, next_pc_select=0, id_ex_bubble=0.
- States are RUN, HOLD and FLUSH.
- Priority within a cycle is branch_taken > hold (stall=0) > run.
- Redirect, in any state when branch_taken=1:
  - Same cycle: pc_write_enable=1, next_pc_select=1, id_ex_bubble=0.
  - Next edge: IF/ID loads NOP with valid=0.
  - If FLUSH_CYCLES=1, next state is RUN. Otherwise next state is FLUSH with flush counter = FLUSH_CYCLES-1.
  - A hold request in the same cycle is discarded.
- RUN/HOLD, when branch_taken=0 and stall=0:
  - Same cycle: pc_write_enable=0, next_pc_select=0, id_ex_bubble=1.
  - IF/ID holds its value. Next state is HOLD. Hold counter increments, saturating at 255.
- RUN/HOLD, when branch_taken=0 and stall=1:
  - Same cycle: pc_write_enable=1, next_pc_select=0, id_ex_bubble=0.
  - IF/ID loads fetch_pc and fetch_instruction with valid=1. Next state is RUN. Hold counter clears.
- FLUSH, when branch_taken=0:
  - stall is ignored because squashed slots cannot create hazards.
  - pc_write_enable=1, next_pc_select=0, id_ex_bubble=0. IF/ID loads NOP with valid=0.
  - Flush counter decrements. When it reaches 1, next state is RUN.
- FLUSH, when branch_taken=1: flush counter reloads to FLUSH_CYCLES-1. A back-to-back redirect extends the flush.
- Watchdog: hold_timeout sets on the edge where hold counter goes from MAX_HOLD_CYCLES-1 to MAX_HOLD_CYCLES. It stays set until reset.
- Reset asserted mid-HOLD or mid-FLUSH discards all state immediately. The first post-reset cycle with stall=1 fetches normally.
- Latency: 1 cycle from fetch inputs to IF/ID outputs. Control outputs are 0 cycles from stall and branch_taken.

Optional Feature:
- PIPELINE_STATS_EN defined:
  - stall_cycle_count increments on every cycle that takes the hold path.
  - flush_count increments on every cycle with branch_taken=1.
  - Both are 16-bit, saturate at 16'hFFFF and clear on reset.
- PIPELINE_STATS_EN undefined: both ports are driven constant 0 and no counter flops exist.

Decomposition:
- Package pipeline_control_pkg holds:
  - the state enum (RUN, HOLD, FLUSH);
  - the NOP_INSTRUCTION default constant;
  - the PC select encodings (PC_PLUS_4=0, PC_BRANCH=1).
- One sub-module, pipeline_event_counter: parameterised-width saturating counter with increment and async clear. It is instantiated twice under PIPELINE_STATS_EN and reused for the hold counter.

Test Plan:
- Release reset with stall=1 and fetch_pc=0x00, 0x04, 0x08 -> if_id_pc follows one cycle later, if_id_valid=1, pc_write_enable=1 throughout.
- stall=0 for 2 cycles while if_id_pc=0x04 -> pc_write_enable=0 and id_ex_bubble=1 for 2 cycles, if_id_pc stays 0x04, then 0x08 loads after release.
- branch_taken=1 with branch_target=0x40, FLUSH_CYCLES=2 -> next_pc_select=1 that cycle, and if_id_valid=0 with instruction 0x00000013 for 2 cycles, then fetch resumes.
- branch_taken=1 and stall=0 in the same cycle -> redirect wins: pc_write_enable=1, id_ex_bubble=0, hold counter not incremented.
- stall=0 held for 15 cycles with MAX_HOLD_CYCLES=15 -> hold_timeout rises on the 15th edge and stays 1 after stall returns to 1.
- With PIPELINE_STATS_EN: 3 hold cycles and 2 redirects -> stall_cycle_count=3, flush_count=2. Assert reset_n=0 mid-FLUSH -> all counters and outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/pipeline_control_pkg.sv
// Shared types and constants for the fetch pipeline controller.
package pipeline_control_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

  localparam logic PC_PLUS_4 = 1'b0;
  localparam logic PC_BRANCH = 1'b1;

  localparam int unsigned FLUSH_CNT_W = 3;
  localparam int unsigned HOLD_CNT_W  = 8;
  localparam int unsigned STAT_CNT_W  = 16;

endpackage

// File: rtl/pipeline_event_counter.sv
// Saturating event counter with synchronous clear and asynchronous reset.
module pipeline_event_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_pipeline_controller.sv
// Turns hold/redirect requests into PC control and the IF/ID register.
// Optional statistics counters are built when PIPELINE_STATS_EN is defined.
module fetch_pipeline_controller
  import pipeline_control_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           FLUSH_CYCLES    = 1,
  parameter int unsigned           MAX_HOLD_CYCLES = 15,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTRUCTION = DATA_WIDTH'(NOP_DEFAULT)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic [DATA_WIDTH-1:0] fetch_pc,
  input  logic [DATA_WIDTH-1:0] fetch_instruction,
  output logic                  pc_write_enable,
  output logic                  next_pc_select,
  output logic                  id_ex_bubble,
  output logic [DATA_WIDTH-1:0] if_id_pc,
  output logic [DATA_WIDTH-1:0] if_id_instruction,
  output logic                  if_id_valid,
  output logic                  hold_timeout,
  output logic [15:0]           stall_cycle_count,
  output logic [15:0]           flush_count
);

  state_e                  state_q, state_d;
  logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [HOLD_CNT_W-1:0]   hold_cnt;
  logic [DATA_WIDTH-1:0]   if_id_pc_q, if_id_pc_d;
  logic [DATA_WIDTH-1:0]   if_id_instr_q, if_id_instr_d;
  logic                    if_id_valid_q, if_id_valid_d;
  logic                    hold_timeout_q, hold_timeout_d;
  logic                    pc_we_c, pc_sel_c, bubble_c;
  logic                    hold_path, run_path;

  // branch_taken has priority over hold; FLUSH ignores stall
  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    pc_we_c       = 1'b1;
    pc_sel_c      = PC_PLUS_4;
    bubble_c      = 1'b0;
    hold_path     = 1'b0;
    run_path      = 1'b0;
    if (branch_taken) begin
      pc_sel_c      = PC_BRANCH;
      if_id_instr_d = NOP_INSTRUCTION;
      if_id_valid_d = 1'b0;
      if (FLUSH_CYCLES <= 1) begin
        state_d     = RUN;
        flush_cnt_d = '0;
      end else begin
        state_d     = FLUSH;
        flush_cnt_d = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
      end
    end else if (state_q == FLUSH) begin
      if_id_instr_d = NOP_INSTRUCTION;
      if_id_valid_d = 1'b0;
      if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
        state_d     = RUN;
        flush_cnt_d = '0;
      end else begin
        flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
      end
    end else if (!stall) begin
      pc_we_c   = 1'b0;
      bubble_c  = 1'b1;
      hold_path = 1'b1;
      state_d   = HOLD;
    end else begin
      run_path      = 1'b1;
      state_d       = RUN;
      if_id_pc_d    = fetch_pc;
      if_id_instr_d = fetch_instruction;
      if_id_valid_d = 1'b1;
    end
  end

  assign hold_timeout_d = hold_timeout_q |
                          (hold_path && (hold_cnt == HOLD_CNT_W'(MAX_HOLD_CYCLES - 1)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= RUN;
      flush_cnt_q    <= '0;
      if_id_pc_q     <= '0;
      if_id_instr_q  <= NOP_INSTRUCTION;
      if_id_valid_q  <= 1'b0;
      hold_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      if_id_pc_q     <= if_id_pc_d;
      if_id_instr_q  <= if_id_instr_d;
      if_id_valid_q  <= if_id_valid_d;
      hold_timeout_q <= hold_timeout_d;
    end
  end

  pipeline_event_counter #(.WIDTH(HOLD_CNT_W)) u_hold_cnt (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .clr_i   (run_path),
    .inc_i   (hold_path),
    .count_o (hold_cnt)
  );

`ifdef PIPELINE_STATS_EN
  pipeline_event_counter #(.WIDTH(STAT_CNT_W)) u_stall_stat (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .clr_i   (1'b0),
    .inc_i   (hold_path),
    .count_o (stall_cycle_count)
  );

  pipeline_event_counter #(.WIDTH(STAT_CNT_W)) u_flush_stat (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .clr_i   (1'b0),
    .inc_i   (branch_taken),
    .count_o (flush_count)
  );
`else
  assign stall_cycle_count = '0;
  assign flush_count       = '0;
`endif

  // Control outputs fall back to plain sequential fetch while in reset
  assign pc_write_enable   = reset_n ? pc_we_c  : 1'b1;
  assign next_pc_select    = reset_n ? pc_sel_c : PC_PLUS_4;
  assign id_ex_bubble      = reset_n ? bubble_c : 1'b0;
  assign if_id_pc          = if_id_pc_q;
  assign if_id_instruction = if_id_instr_q;
  assign if_id_valid       = if_id_valid_q;
  assign hold_timeout      = hold_timeout_q;

endmodule

// File: tb/tb_fetch_pipeline_controller.sv
// Directed self-checking bench for fetch_pipeline_controller (FLUSH_CYCLES=2).
module tb_fetch_pipeline_controller;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instruction;
  logic        pc_write_enable;
  logic        next_pc_select;
  logic        id_ex_bubble;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic        hold_timeout;
  logic [15:0] stall_cycle_count;
  logic [15:0] flush_count;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_pipeline_controller #(
    .DATA_WIDTH      (32),
    .FLUSH_CYCLES    (2),
    .MAX_HOLD_CYCLES (15)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .fetch_pc          (fetch_pc),
    .fetch_instruction (fetch_instruction),
    .pc_write_enable   (pc_write_enable),
    .next_pc_select    (next_pc_select),
    .id_ex_bubble      (id_ex_bubble),
    .if_id_pc          (if_id_pc),
    .if_id_instruction (if_id_instruction),
    .if_id_valid       (if_id_valid),
    .hold_timeout      (hold_timeout),
    .stall_cycle_count (stall_cycle_count),
    .flush_count       (flush_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] stat(input int v);
`ifdef PIPELINE_STATS_EN
    return 32'(v);
`else
    return 32'(v * 0);
`endif
  endfunction

  // Drive one cycle from a negedge, check the combinational controls, then
  // advance past the posedge to the next negedge.
  task automatic cyc(input logic st, input logic br, input logic [31:0] tgt,
                     input logic [31:0] pc, input logic [31:0] ins,
                     input logic ewe, input logic esel, input logic ebub);
    stall = st; branch_taken = br; branch_target = tgt;
    fetch_pc = pc; fetch_instruction = ins;
    #1;
    check("pc_write_enable", 32'(pc_write_enable), 32'(ewe));
    check("next_pc_select",  32'(next_pc_select),  32'(esel));
    check("id_ex_bubble",    32'(id_ex_bubble),    32'(ebub));
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc,
                            input logic [31:0] ins, input logic v);
    check({tag, "_pc"},    if_id_pc,          pc);
    check({tag, "_instr"}, if_id_instruction, ins);
    check({tag, "_valid"}, 32'(if_id_valid),  32'(v));
  endtask

  task automatic check_reset_state(input string tag);
    check_ifid(tag, 32'h0, NOP, 1'b0);
    check({tag, "_pc_we"},   32'(pc_write_enable), 32'h1);
    check({tag, "_sel"},     32'(next_pc_select),  32'h0);
    check({tag, "_bubble"},  32'(id_ex_bubble),    32'h0);
    check({tag, "_timeout"}, 32'(hold_timeout),    32'h0);
    check({tag, "_stall_cnt"}, 32'(stall_cycle_count), 32'h0);
    check({tag, "_flush_cnt"}, 32'(flush_count),       32'h0);
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    branch_target = '0; fetch_pc = '0; fetch_instruction = '0;
    #12;
    // stall=0 during reset must not affect the control outputs
    check_reset_state("reset");
    @(negedge clock);
    stall = 1'b1;
    reset_n = 1'b1;

    cyc(1'b1, 1'b0, 32'h0, 32'h00, 32'hA0, 1'b1, 1'b0, 1'b0);
    check_ifid("run0", 32'h00, 32'hA0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 32'h04, 32'hA4, 1'b1, 1'b0, 1'b0);
    check_ifid("run1", 32'h04, 32'hA4, 1'b1);

    cyc(1'b0, 1'b0, 32'h0, 32'h08, 32'hA8, 1'b0, 1'b0, 1'b1);
    check_ifid("hold0", 32'h04, 32'hA4, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 32'h08, 32'hA8, 1'b0, 1'b0, 1'b1);
    check_ifid("hold1", 32'h04, 32'hA4, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 32'h08, 32'hA8, 1'b1, 1'b0, 1'b0);
    check_ifid("release", 32'h08, 32'hA8, 1'b1);

    // redirect together with a hold request: redirect wins
    cyc(1'b0, 1'b1, 32'h40, 32'h0C, 32'hAC, 1'b1, 1'b1, 1'b0);
    check("redir_instr", if_id_instruction, NOP);
    check("redir_valid", 32'(if_id_valid), 32'h0);
    // flush slot ignores stall
    cyc(1'b0, 1'b0, 32'h0, 32'h40, 32'hB0, 1'b1, 1'b0, 1'b0);
    check("flush_instr", if_id_instruction, NOP);
    check("flush_valid", 32'(if_id_valid), 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 32'h44, 32'hB4, 1'b1, 1'b0, 1'b0);
    check_ifid("resume", 32'h44, 32'hB4, 1'b1);
    check("stall_cnt_a", 32'(stall_cycle_count), stat(2));
    check("flush_cnt_a", 32'(flush_count), stat(1));
    check("timeout_a", 32'(hold_timeout), 32'h0);

    // watchdog: rises on the 15th consecutive hold edge
    for (int i = 1; i <= 15; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 32'h48, 32'hB8, 1'b0, 1'b0, 1'b1);
      if (i == 14) check("timeout_14", 32'(hold_timeout), 32'h0);
    end
    check("timeout_15", 32'(hold_timeout), 32'h1);
    check_ifid("long_hold", 32'h44, 32'hB4, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 32'h48, 32'hB8, 1'b1, 1'b0, 1'b0);
    check("timeout_sticky", 32'(hold_timeout), 32'h1);
    check_ifid("after_long", 32'h48, 32'hB8, 1'b1);
    check("stall_cnt_b", 32'(stall_cycle_count), stat(17));

    // back-to-back redirects extend the flush
    cyc(1'b1, 1'b1, 32'h80, 32'h4C, 32'hBC, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 32'hC0, 32'h80, 32'hC4, 1'b1, 1'b1, 1'b0);
    check("b2b_valid", 32'(if_id_valid), 32'h0);
    check("flush_cnt_b", 32'(flush_count), stat(3));
    stall = 1'b0; branch_taken = 1'b0;
    #1;
    check("flushing_pc_we", 32'(pc_write_enable), 32'h1);
    check("flushing_bubble", 32'(id_ex_bubble), 32'h0);

    // asynchronous reset mid-flush
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_state("mid_flush_reset");
    @(negedge clock);
    reset_n = 1'b1;
    cyc(1'b1, 1'b0, 32'h0, 32'h100, 32'hD0, 1'b1, 1'b0, 1'b0);
    check_ifid("post_reset", 32'h100, 32'hD0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
